// File: rtl/seg_frame_capture.sv
// seg_frame_capture: watches a multiplexed active-low 7-segment bus and
// rebuilds the digit codes being shown, one digit per anode position.
// Each digit is accepted only after its (anode, segment) pair has been
// stable for STABLE_CYCLES samples. When all positions have been seen,
// the collected frame is offered over a valid/ready handshake.
`timescale 1ns/1ps
module seg_frame_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  input  logic                  frame_ready,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  output logic                  overrun
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    CAPTURED
  } state_t;

  state_t                state_q, state_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   work_q, work_d;
  logic [DIGITS-1:0]     work_err_q, work_err_d;
  logic [DIGITS-1:0]     seen_q, seen_d;
  logic [4*DIGITS-1:0]   digits_q, digits_d;
  logic [DIGITS-1:0]     digit_err_q, digit_err_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  overrun_q, overrun_d;

  logic [DIGITS-1:0]     an_low;
  logic                  an_valid;
  logic [3:0]            code;
  logic                  code_err;
  logic                  capture;
  logic                  frame_done;
  logic                  transfer;

  // Register the bus every cycle and count how long the sample has held.
  always_comb begin
    an_d  = an;
    seg_d = seg;
    if ((an == an_q) && (seg == seg_q)) begin
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd1;
    end
  end

  // A usable sample has exactly one anode driven low; that bit selects the slot.
  always_comb begin
    an_low   = ~an_q;
    an_valid = $onehot(an_low);
  end

  // Translate the sampled segment pattern into a digit code.
  always_comb begin
    code     = 4'hF;
    code_err = 1'b0;
    case (seg_q)
      7'b0000001: code = 4'd0;
      7'b1001111: code = 4'd1;
      7'b0010010: code = 4'd2;
      7'b0000110: code = 4'd3;
      7'b1001100: code = 4'd4;
      7'b0100100: code = 4'd5;
      7'b0100000: code = 4'd6;
      7'b0001111: code = 4'd7;
      7'b0000000: code = 4'd8;
      7'b0000100: code = 4'd9;
      7'b1111110: code = 4'd10;
      7'b1111111: code = 4'd11;
      default: begin
        code     = 4'hF;
        code_err = 1'b1;
      end
    endcase
  end

  // Capture FSM: a new sample must be stable long enough before it is taken.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (an_valid) begin
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (!an_valid) begin
          state_d = IDLE;
        end else if (cnt_q >= STABLE_LIM) begin
          capture = 1'b1;
          state_d = CAPTURED;
        end
      end
      CAPTURED: begin
        if (cnt_q == 8'd1) begin
          state_d = an_valid ? TRACK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Collect captured digits and hand complete frames to the consumer.
  always_comb begin
    work_d        = work_q;
    work_err_d    = work_err_q;
    seen_d        = seen_q;
    digits_d      = digits_q;
    digit_err_d   = digit_err_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    transfer      = frame_valid_q & frame_ready;

    for (int i = 0; i < DIGITS; i++) begin
      if (capture && an_low[i]) begin
        work_d[4*i +: 4] = code;
        work_err_d[i]    = code_err;
        seen_d[i]        = 1'b1;
      end
    end

    frame_done = capture && (&seen_d);
    if (frame_done) begin
      seen_d = '0;
    end

    if (transfer) begin
      frame_valid_d = 1'b0;
    end

    if (frame_done) begin
      if (!frame_valid_q || transfer) begin
        digits_d      = work_d;
        digit_err_d   = work_err_d;
        frame_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and data registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      an_q          <= '0;
      seg_q         <= '0;
      cnt_q         <= '0;
      work_q        <= '0;
      work_err_q    <= '0;
      seen_q        <= '0;
      digits_q      <= '0;
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      cnt_q         <= cnt_d;
      work_q        <= work_d;
      work_err_q    <= work_err_d;
      seen_q        <= seen_d;
      digits_q      <= digits_d;
      digit_err_q   <= digit_err_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign digits      = digits_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;

endmodule
